// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: button conditioning, run/pause/expire FSM,
// lap capture buffer with timed lap display, and expiry flash generation.
module stopwatch_ctrl #(
  parameter int LAP_DEPTH = 4,
  parameter int HOLD_MS   = 2000,
  parameter int FLASH_MS  = 250
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         lap,
  input  logic                         clr,
  input  logic                         dir,
  input  logic                         tick_1ms,
  input  logic [15:0]                  cur_time,
  input  logic                         at_limit,
  output logic                         cnt_en,
  output logic                         cnt_clr,
  output logic [15:0]                  disp_time,
  output logic                         disp_is_lap,
  output logic                         flash,
  output logic                         lap_full,
  output logic [1:0]                   state,
  output logic [$clog2(LAP_DEPTH):0]   lap_count
);

  localparam int CW = $clog2(LAP_DEPTH) + 1;
  localparam int IW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int HW = $clog2(HOLD_MS + 1);
  localparam int FW = $clog2(FLASH_MS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t          st, st_nxt;
  logic [3:0]      sync1, sync2, hist, press;
  logic            start_p, stop_p, lap_p, clr_p;
  logic            do_clr, do_cap, do_view;
  logic            dir_entry;
  logic [HW-1:0]   hold_cnt;
  logic [FW-1:0]   flash_cnt;
  logic [CW-1:0]   lap_idx;
  logic            lap_view;
  logic [15:0]     lap_mem [LAP_DEPTH];
  logic [15:0]     last_lap;

  // Button conditioning: two-flop synchroniser, history flop, rising-edge press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= {clr, lap, stop, start};
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign press   = sync2 & ~hist;
  assign start_p = press[0];
  assign stop_p  = press[1];
  assign lap_p   = press[2];
  assign clr_p   = press[3];

  assign state    = st;
  assign lap_full = (lap_count == CW'(LAP_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= st_nxt;
  end

  // Only one action per cycle; clear overrides everything, then per-state priority
  always_comb begin
    st_nxt  = st;
    do_clr  = 1'b0;
    do_cap  = 1'b0;
    do_view = 1'b0;
    if (clr_p) begin
      st_nxt = IDLE;
      do_clr = 1'b1;
    end else begin
      case (st)
        IDLE:    if (start_p) st_nxt = RUN;
        RUN: begin
          if (at_limit)               st_nxt = EXPIRED;
          else if (stop_p)            st_nxt = PAUSED;
          else if (lap_p && !lap_full) do_cap = 1'b1;
        end
        PAUSED: begin
          if (start_p)                          st_nxt  = RUN;
          else if (lap_p && lap_count != '0)    do_view = 1'b1;
        end
        EXPIRED: if (dir != dir_entry) st_nxt = PAUSED;
        default: st_nxt = IDLE;
      endcase
    end
  end

  // Control registers: counter strobes, lap bookkeeping, hold and flash timers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      lap_count <= '0;
      hold_cnt  <= '0;
      flash     <= 1'b0;
      flash_cnt <= '0;
      lap_idx   <= '0;
      lap_view  <= 1'b0;
      dir_entry <= 1'b0;
    end else begin
      cnt_en  <= (st_nxt == RUN);
      cnt_clr <= do_clr;

      if (do_clr)      lap_count <= '0;
      else if (do_cap) lap_count <= lap_count + CW'(1);

      if (do_cap)                         hold_cnt <= HW'(HOLD_MS);
      else if (st_nxt != RUN)             hold_cnt <= '0;
      else if (tick_1ms && hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);

      if (st_nxt == EXPIRED) begin
        if (st != EXPIRED) begin
          flash     <= 1'b1;
          flash_cnt <= '0;
          dir_entry <= dir;
        end else if (tick_1ms) begin
          if (flash_cnt == FW'(FLASH_MS - 1)) begin
            flash_cnt <= '0;
            flash     <= ~flash;
          end else begin
            flash_cnt <= flash_cnt + FW'(1);
          end
        end
      end else begin
        flash     <= 1'b0;
        flash_cnt <= '0;
      end

      // First lap press in PAUSED shows slot 0, later presses walk the stored laps
      if (st_nxt != PAUSED) begin
        lap_view <= 1'b0;
        lap_idx  <= '0;
      end else if (do_view) begin
        lap_view <= 1'b1;
        if (!lap_view || (lap_idx + CW'(1) == lap_count)) lap_idx <= '0;
        else                                                lap_idx <= lap_idx + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_cap) begin
      lap_mem[lap_count[IW-1:0]] <= cur_time;
      last_lap                   <= cur_time;
    end
  end

  assign disp_is_lap = ((st == RUN) && (hold_cnt != '0)) || ((st == PAUSED) && lap_view);
  assign disp_time   = !disp_is_lap ? cur_time :
                       (st == RUN)  ? last_lap : lap_mem[lap_idx[IW-1:0]];

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter LAP_DEPTH, default 4: number of stored lap times.
REQ-002 SHALL have parameter HOLD_MS, default 2000: tick_1ms pulses a captured lap stays on the display.
REQ-003 SHALL have parameter FLASH_MS, default 250: tick_1ms pulses per flash half-period.
REQ-004 SHALL have port clk, input, 1: system clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports start, stop, lap, clr, inputs, 1 each: raw asynchronous push buttons, active-high.
REQ-007 SHALL have port dir, input, 1: count direction, 1=up, 0=down.
REQ-008 SHALL have port tick_1ms, input, 1: one-clk pulse every 1 ms.
REQ-009 SHALL have port cur_time, input, 16: live counter value, BCD {minutes, sec_msd, sec_lsd, ms}.
REQ-010 SHALL have port at_limit, input, 1: counter is at 9:59.9 (up) or 0:00.0 (down).
REQ-011 SHALL have port cnt_en, output, 1: counter enable.
REQ-012 SHALL have port cnt_clr, output, 1: one-clk counter clear pulse.
REQ-013 SHALL have port disp_time, output, 16: time to display.
REQ-014 SHALL have ports disp_is_lap, flash, lap_full, outputs, 1 each: lap shown, display blank toggle, lap buffer full.
REQ-015 SHALL have ports state, output, 2, and lap_count, output, $clog2(LAP_DEPTH)+1.

Function
REQ-016 Each button SHALL pass through a 2-flop synchroniser plus a history flop; press = sync2 & ~hist; a button first sampled high at edge N yields a press pulse in cycle N+1..N+2 and the FSM acts at edge N+2.
REQ-017 A held button SHALL produce exactly one press pulse.
REQ-018 FSM states SHALL be IDLE=0, RUN=1, PAUSED=2, EXPIRED=3.
REQ-019 Press priority in one cycle SHALL be clr > at_limit > stop > start > lap.
REQ-020 clr press in any state SHALL go to IDLE, assert cnt_clr for one cycle, empty the lap buffer, and cancel hold and flash.
REQ-021 IDLE: start -> RUN; stop and lap ignored.
REQ-022 RUN: at_limit=1 -> EXPIRED; stop -> PAUSED; lap -> capture cur_time into the next free lap slot when lap_count<LAP_DEPTH, and load the hold timer with HOLD_MS.
REQ-023 PAUSED: start -> RUN and drop disp_is_lap; lap with lap_count>0 -> show lap index 0 on first press, then advance mod lap_count; lap with lap_count==0 is ignored.
REQ-024 EXPIRED: start, stop and lap are ignored; a dir change from its value at entry -> PAUSED.
REQ-025 cnt_en SHALL equal (state==RUN), registered.
REQ-026 A lap press in RUN with a full buffer SHALL change nothing; lap_full=(lap_count==LAP_DEPTH).
REQ-027 The hold timer SHALL decrement once per tick_1ms.
REQ-028 While the hold timer is nonzero in RUN, disp_time SHALL equal the last captured lap and disp_is_lap=1.
REQ-029 When the hold timer reaches 0, disp_time SHALL revert to cur_time.
REQ-030 A new capture during a hold SHALL reload the timer with HOLD_MS.
REQ-031 Leaving RUN SHALL clear the hold timer.
REQ-032 When disp_is_lap=0, disp_time SHALL equal cur_time combinationally.
REQ-033 On entry to EXPIRED, flash SHALL be 1 and SHALL toggle every FLASH_MS tick_1ms pulses.
REQ-034 flash SHALL be 0 in every other state.
REQ-035 lap_count SHALL saturate at LAP_DEPTH and never wrap.

Reset
REQ-036 On rst=0, state SHALL be IDLE and cnt_en, cnt_clr, disp_is_lap, flash, lap_full and lap_count SHALL be 0.
REQ-037 On rst=0, sync/history flops, hold timer, flash timer and lap index SHALL be 0, and disp_time SHALL follow cur_time.
REQ-038 Reset SHALL take effect immediately, mid-operation included.
REQ-039 After rst deasserts, a button already held high SHALL produce one press pulse, since the history flop resets to 0.

Verification
REQ-040 start pulse at edge N -> state=RUN and cnt_en=1 after edge N+2; stop pulse -> PAUSED, cnt_en=0.
REQ-041 In RUN, 5 lap presses with LAP_DEPTH=4 -> lap_count=4, lap_full=1, 5th press ignored; disp_is_lap=1 for exactly 2000 ticks after each capture.
REQ-042 RUN with cur_time=16'h0000, dir=0, at_limit=1 -> EXPIRED, cnt_en=0, flash=1 toggling every 250 ticks; then toggle dir -> PAUSED, flash=0.
REQ-043 Same-cycle clr and stop presses in RUN -> IDLE, cnt_clr high for exactly one cycle, lap_count=0.
REQ-044 PAUSED with 3 stored laps, 4 lap presses -> disp_time shows lap0, lap1, lap2, lap0; then start -> RUN, disp_is_lap=0.
REQ-045 rst=0 asserted mid-hold in RUN -> all outputs reset within the same cycle with no clock edge needed.
